// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES request arbiter.
package aes_ctrl_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    localparam logic AES_MODE_ENC = 1'b0;
    localparam logic AES_MODE_DEC = 1'b1;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } aes_arb_state_e;

endpackage

// File: rtl/aes_rr_picker.sv
// Combinational round-robin picker: first valid requester found searching
// upward from i_rr_ptr with wrap-around. Outputs one-hot grant and its index.
module aes_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    // Candidate index for each search step, already wrapped into range.
    logic [IDX_W-1:0] w_idx [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_idx
        assign w_idx[k] = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
    end

    // Take the first valid candidate in search order.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && i_req_valid[w_idx[k]]) begin
                o_any                = 1'b1;
                o_grant[w_idx[k]]    = 1'b1;
                o_grant_idx          = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one aes_core between NUM_REQ requesters. Round-robin arbitration in
// IDLE, one-cycle core_start in ISSUE, wait for core_done in WAIT, hold the
// response in RESP until the granted requester takes it.
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; req_ready is only offered in IDLE, resp_valid is held (with stable
// resp_data/resp_err) until resp_ready of the granted requester is seen.
// Optional watchdog in WAIT: define AES_REQ_ARB_TIMEOUT_EN.
module aes_req_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_mode,
    input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_block,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [AES_BLOCK_W-1:0]         resp_data,
    output logic                           resp_err,
    output logic                           busy,
    output logic                           core_start,
    output logic                           core_mode,
    output logic [AES_KEY_W-1:0]           core_key,
    output logic [AES_BLOCK_W-1:0]         core_block_in,
    input  logic [AES_BLOCK_W-1:0]         core_block_out,
    input  logic                           core_done,
    output aes_arb_state_e                 dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("aes_req_arbiter: NUM_REQ must be 2..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("aes_req_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    aes_arb_state_e r_state;
    aes_arb_state_e w_next_state;

    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_gnt_idx;
    logic [AES_KEY_W-1:0]   r_key;
    logic [AES_BLOCK_W-1:0] r_block;
    logic                   r_mode;
    logic [AES_BLOCK_W-1:0] r_resp_data;

    logic [NUM_REQ-1:0]     w_grant;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_any;
    logic                   w_accept;
    logic                   w_done_in_wait;
    logic                   w_timeout;
    logic [IDX_W-1:0]       w_next_ptr;

    logic [AES_KEY_W-1:0]   w_key_arr   [NUM_REQ];
    logic [AES_BLOCK_W-1:0] w_block_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_key_arr[i]   = req_key[i*AES_KEY_W +: AES_KEY_W];
        assign w_block_arr[i] = req_block[i*AES_BLOCK_W +: AES_BLOCK_W];
    end

    aes_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_accept       = (r_state == ARB_IDLE) && w_any;
    assign w_done_in_wait = (r_state == ARB_WAIT) && core_done;
    assign w_next_ptr     = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : w_grant_idx + IDX_W'(1);

`ifdef AES_REQ_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_resp_err;

    // Watchdog: zero on the first WAIT cycle, +1 per WAIT cycle. It fires on
    // the TIMEOUT_CYCLES-th WAIT cycle so RESP lands exactly TIMEOUT_CYCLES
    // cycles after WAIT was entered. A done in that same cycle takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (r_state == ARB_ISSUE) begin
            r_wd_cnt <= '0;
        end else if (r_state == ARB_WAIT) begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ARB_WAIT) && !core_done &&
                       (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Error flag: cleared by a real result, set by a watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_err <= 1'b0;
        end else if (w_done_in_wait) begin
            r_resp_err <= 1'b0;
        end else if (w_timeout) begin
            r_resp_err <= 1'b1;
        end
    end

    assign resp_err = r_resp_err;
`else
    assign w_timeout = 1'b0;
    assign resp_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ARB_IDLE:  if (w_any) w_next_state = ARB_ISSUE;
            ARB_ISSUE: w_next_state = ARB_WAIT;
            ARB_WAIT:  if (core_done || w_timeout) w_next_state = ARB_RESP;
            ARB_RESP:  if (resp_ready[r_gnt_idx]) w_next_state = ARB_IDLE;
            default:   w_next_state = ARB_IDLE;
        endcase
    end

    // Latch the winner's request and advance the round-robin pointer on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key     <= '0;
            r_block   <= '0;
            r_mode    <= AES_MODE_ENC;
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
        end else if (w_accept) begin
            r_key     <= w_key_arr[w_grant_idx];
            r_block   <= w_block_arr[w_grant_idx];
            r_mode    <= req_mode[w_grant_idx];
            r_gnt_idx <= w_grant_idx;
            r_rr_ptr  <= w_next_ptr;
        end
    end

    // Capture the core result (or zero on watchdog expiry) for the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_data <= '0;
        end else if (w_done_in_wait) begin
            r_resp_data <= core_block_out;
        end else if (w_timeout) begin
            r_resp_data <= '0;
        end
    end

    assign req_ready     = (r_state == ARB_IDLE) ? w_grant : '0;
    assign resp_valid    = (r_state == ARB_RESP) ? (NUM_REQ'(1) << r_gnt_idx) : '0;
    assign resp_data     = r_resp_data;
    assign busy          = (r_state != ARB_IDLE);
    assign core_start    = (r_state == ARB_ISSUE);
    assign core_mode     = r_mode;
    assign core_key      = r_key;
    assign core_block_in = r_block;
    assign dbg_state     = r_state;

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Shares one `aes_core` instance between `NUM_REQ` independent requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, latches the winner's key, block and mode, and holds them stable on the combinational core for the whole operation. It sequences the `start`/`done` pulse pair, captures the result, and returns it to the granted requester. It sits between the crypto clients and `aes_core` in the crypto subsystem.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `TIMEOUT_CYCLES`, 16: watchdog limit in WAIT. Used only with `AES_REQ_ARB_TIMEOUT_EN`.
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high (one-hot).
- `req_mode`  in  NUM_REQ  per requester; 0 = encrypt, 1 = decrypt.
- `req_key`  in  NUM_REQ×128  packed; requester i occupies bits [128i+127:128i].
- `req_block`  in  NUM_REQ×128  packed, same layout as `req_key`.
- `resp_valid`  out  NUM_REQ  result available for requester i; one-hot.
- `resp_ready`  in  NUM_REQ  per-requester response accept.
- `resp_data`  out  128  result block, shared across requesters.
- `resp_err`  out  1  timeout flag, qualified by `resp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `core_start`  out  1  to `aes_core.start`.
- `core_mode`  out  1  to `aes_core.mode`.
- `core_key`  out  128  to `aes_core.key`.
- `core_block_in`  out  128  to `aes_core.block_in`.
- `core_block_out`  in  128  from `aes_core.block_out`.
- `core_done`  in  1  from `aes_core.done`.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, pick a winner g by round-robin, searching upward from pointer `rr_ptr` with wrap.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Latch `req_key[g]`, `req_block[g]`, `req_mode[g]` and `g` into internal registers.
  - Set `rr_ptr <= (g+1) mod NUM_REQ`, then go to ISSUE.
  - If no `req_valid` is high, stay in IDLE.
- **ISSUE:** `core_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT:**
  - On `core_done`=1, capture `core_block_out` into `resp_data`, clear `resp_err`, go to RESP.
  - Otherwise stay in WAIT.
- **RESP:**
  - `resp_valid[g]`=1.
  - When `resp_ready[g]`=1, go to IDLE.
  - No new request is accepted in this cycle.
- **Core inputs:** `core_key`, `core_block_in` and `core_mode` are driven from the latched registers at all times. They change only on the accepting IDLE cycle.
- **Requester signals:** `req_*` are ignored except on the accepting cycle. Requesters may change them after the handshake.
- **Stray done:** `core_done` outside WAIT is ignored.
- **Simultaneous requests:** all requesters valid together are served in strict rotation 0,1,…,NUM_REQ−1,0.

## Timing
- **Reset values:** `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `busy`=0, `core_start`=0. Latched key/block/mode = 0, `rr_ptr`=0, state = IDLE.
- **Reset mid-operation:** an in-flight result is discarded with no response. The first request after reset is granted from requester 0 upward.
- **Latency:**
  - Accept at cycle T.
  - `core_start` at T+1.
  - `core_done` at T+2 (the core registers its start).
  - `resp_valid` at T+3.
- **Throughput:** with `resp_ready` held high, one operation per 4 cycles.
- **Response hold:** `resp_data`, `resp_err` and `resp_valid` stay stable until consumed.

## Configuration
- **`AES_REQ_ARB_TIMEOUT_EN` defined:**
  - A counter is cleared on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `core_done`, go to RESP with `resp_err`=1 and `resp_data`=0.
  - A `core_done` arriving in the same cycle as the timeout wins: the response is normal, with `resp_err`=0.
- **`AES_REQ_ARB_TIMEOUT_EN` undefined:** no counter is present, `resp_err` is tied to 0, and WAIT waits indefinitely.

## Structure
- **Package `aes_ctrl_pkg`:**
  - state enum `aes_arb_state_e`;
  - `AES_BLOCK_W`=128, `AES_KEY_W`=128;
  - `AES_MODE_ENC`=1'b0, `AES_MODE_DEC`=1'b1.
- **Sub-module `aes_rr_picker`:** combinational. Inputs are the `req_valid` vector and `rr_ptr`. Outputs are a one-hot grant and its index.
- **Not in this block:** the FSM, latches and watchdog stay in `aes_req_arbiter`. `aes_core` is instantiated by the parent, not inside this block.

## Test plan
- **FIPS-197 encrypt:** requester 0, key 000102…0f, block 00112233445566778899aabbccddeeff, mode 0 → `resp_valid[0]` at T+3 with `resp_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `resp_err`=0.
- **FIPS-197 decrypt:** requester 1, same key, block 69c4e0d8…c55a, mode 1 → `resp_data`=00112233…eeff on `resp_valid[1]` only.
- **Fairness:** all requesters valid continuously for 8 operations → grant order 0,1,0,1,… (NUM_REQ=2) and `core_start` every 4 cycles.
- **Backpressure:** hold `resp_ready`=0 for 10 cycles in RESP → `resp_data` stable, `req_ready` all 0, no `core_start`.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT → all outputs at reset values. After release, a new request from requester 1 while requester 0 is idle completes normally.
- **Timeout:** with `AES_REQ_ARB_TIMEOUT_EN` and a stub that never asserts `core_done` → `resp_valid` exactly `TIMEOUT_CYCLES` cycles after entering WAIT, with `resp_err`=1 and `resp_data`=0.
